regfile_write_arbiter: RTL and testbench

Owns the CPU register file's single write port. After reset it sweeps zeros into x1..x31 so no architectural register powers up undefined. It then shares the port between two writeback requesters, the ALU and the load unit, using round-robin valid/ready arbitration. The block sits between the writeback sources and `register_file`, and drives that block's `write_enable`, `write_addr` and `write_data` inputs directly.

---
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Owns the single write port of the CPU register file. After reset it
// optionally sweeps zeros into x1..x31. It then shares the port between the
// ALU and load-unit writeback requesters with round-robin valid/ready
// arbitration.
//
// Parameters:
//   CLEAR_ON_RESET  1: run the zeroing sweep after reset, 0: start in RUN
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   alu_wb_valid/addr/data, alu_wb_ready   ALU writeback request channel
//   mem_wb_valid/addr/data, mem_wb_ready   load writeback request channel
//   rf_write_enable/addr/data              registered register_file write port
//   init_done       registered, high once the block is in RUN
module regfile_write_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_addr,
  input  logic [31:0] mem_wb_data,
  output logic        mem_wb_ready,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        init_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  state_t      state_reg;
  logic [4:0]  clear_ctr_reg;
  logic        last_grant_reg;
  logic        we_reg;
  logic [4:0]  addr_reg;
  logic [31:0] data_reg;
  logic        init_done_reg;

  logic        alu_grant;
  logic        mem_grant;

  // Round-robin grant. Contention goes to the requester that did not win
  // last; a lone requester always wins. Readys are also forced low while
  // reset is asserted so they read 0 even when the block resets into RUN.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (state_reg == ST_RUN && !reset) begin
      if (alu_wb_valid && mem_wb_valid) begin
        alu_grant = (last_grant_reg == GRANT_MEM);
        mem_grant = (last_grant_reg == GRANT_ALU);
      end else begin
        alu_grant = alu_wb_valid;
        mem_grant = mem_wb_valid;
      end
    end
  end

  assign alu_wb_ready    = alu_grant;
  assign mem_wb_ready    = mem_grant;
  assign rf_write_enable = we_reg;
  assign rf_write_addr   = addr_reg;
  assign rf_write_data   = data_reg;
  assign init_done       = init_done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clear_ctr_reg  <= 5'd1;
      last_grant_reg <= GRANT_MEM;
      we_reg         <= 1'b0;
      addr_reg       <= 5'd0;
      data_reg       <= 32'd0;
      init_done_reg  <= ~CLEAR_ON_RESET;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          // One zero write per cycle, x1 up to x31; x0 is never addressed.
          we_reg        <= 1'b1;
          addr_reg      <= clear_ctr_reg;
          data_reg      <= 32'd0;
          clear_ctr_reg <= clear_ctr_reg + 5'd1;
          if (clear_ctr_reg == 5'd31) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (alu_grant) begin
            addr_reg       <= alu_wb_addr;
            data_reg       <= alu_wb_data;
            // x0 writes are accepted but suppressed at the port.
            we_reg         <= (alu_wb_addr != 5'd0);
            last_grant_reg <= GRANT_ALU;
          end else if (mem_grant) begin
            addr_reg       <= mem_wb_addr;
            data_reg       <= mem_wb_data;
            we_reg         <= (mem_wb_addr != 5'd0);
            last_grant_reg <= GRANT_MEM;
          end else begin
            // Idle: drop the enable, keep address and data as they were.
            we_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rst0;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_addr;
  logic [31:0] mem_wb_data;

  logic        alu_wb_ready, mem_wb_ready, rf_write_enable, init_done;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  logic        alu_ready0, mem_ready0, rf_we0, init_done0;
  logic [4:0]  rf_addr0;
  logic [31:0] rf_data0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .init_done(init_done)
  );

  regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(rst0),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_ready0),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_ready0),
    .rf_write_enable(rf_we0), .rf_write_addr(rf_addr0),
    .rf_write_data(rf_data0), .init_done(init_done0)
  );

  // Behavioural register file fed by the DUT write port.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected register contents, expected write-port values
  // now (cur_*) and after the next edge (exp_*), round-robin memory and
  // sweep position, plus the pending request of each requester.
  logic [31:0] ref_rf [32];
  bit          m_last;        // 1: MEM won most recently
  int          m_clear_idx;   // next sweep address, >31 means running
  bit          cur_we, exp_we, cur_init, exp_init;
  logic [4:0]  cur_addr, exp_addr;
  logic [31:0] cur_data, exp_data;
  bit          a_v, p_v;
  logic [4:0]  a_addr, p_addr;
  logic [31:0] a_data, p_data;

  task automatic model_reset();
    cur_we = 0; cur_addr = '0; cur_data = '0; cur_init = 0;
    m_last = 1'b1;
    m_clear_idx = 1;
  endtask

  // Clock edge: the register file absorbs what was on the port, the port
  // shows the previously predicted values.
  task automatic advance();
    @(posedge clk);
    #1;
    if (cur_we) ref_rf[cur_addr] = cur_data;
    cur_we = exp_we; cur_addr = exp_addr; cur_data = exp_data; cur_init = exp_init;
    check("rf_we", rf_write_enable, cur_we);
    check("rf_addr", rf_write_addr, cur_addr);
    check("rf_data", rf_write_data, cur_data);
    check("init_done", init_done, cur_init);
  endtask

  // Present the pending requests, check the readys and predict the next edge.
  task automatic decide();
    bit ga, gm;
    alu_wb_valid = a_v; alu_wb_addr = a_addr; alu_wb_data = a_data;
    mem_wb_valid = p_v; mem_wb_addr = p_addr; mem_wb_data = p_data;
    #1;
    ga = 0; gm = 0;
    if (m_clear_idx <= 31) begin
      exp_we = 1; exp_addr = m_clear_idx[4:0]; exp_data = '0;
      exp_init = (m_clear_idx == 31);
      m_clear_idx++;
    end else begin
      if (a_v && p_v) begin
        ga = m_last;
        gm = !m_last;
      end else begin
        ga = a_v;
        gm = p_v;
      end
      exp_init = 1; exp_we = 0; exp_addr = cur_addr; exp_data = cur_data;
      if (ga) begin
        exp_addr = a_addr; exp_data = a_data; exp_we = (a_addr != 0);
        m_last = 0; a_v = 0;
        $display("txn t=%0t port=ALU addr=%0d data=%08h", $time, a_addr, a_data);
      end else if (gm) begin
        exp_addr = p_addr; exp_data = p_data; exp_we = (p_addr != 0);
        m_last = 1; p_v = 0;
        $display("txn t=%0t port=MEM addr=%0d data=%08h", $time, p_addr, p_data);
      end
    end
    check("alu_ready", alu_wb_ready, ga);
    check("mem_ready", mem_wb_ready, gm);
    check("ready_both", alu_wb_ready & mem_wb_ready, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = (i == 0) ? 32'd0 : (32'hA5A5_0000 | i);
      ref_rf[i] = rf_mem[i];
    end
    reset = 1; rst0 = 1;
    a_v = 0; p_v = 0; a_addr = '0; p_addr = '0; a_data = '0; p_data = '0;
    alu_wb_valid = 0; mem_wb_valid = 0;
    alu_wb_addr = '0; mem_wb_addr = '0; alu_wb_data = '0; mem_wb_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", rf_write_enable, 0);
    check("rst_addr", rf_write_addr, 0);
    check("rst_data", rf_write_data, 0);
    check("rst_init", init_done, 0);
    check("rst_alu_ready", alu_wb_ready, 0);
    check("rst_mem_ready", mem_wb_ready, 0);
    check("rst0_init", init_done0, 1);
    check("rst0_we", rf_we0, 0);

    // Sweep with both requesters already valid: readys must stay low.
    a_v = 1; a_addr = 5'd1; a_data = 32'h1111_1111;
    p_v = 1; p_addr = 5'd2; p_data = 32'h2222_2222;
    reset = 0;
    decide();
    for (int i = 1; i <= 31; i++) begin
      advance();
      if (i < 31) decide();
    end

    // Continuous contention: ALU, MEM, ALU, MEM.
    for (int k = 0; k < 4; k++) begin
      a_v = 1; a_addr = 5'd1; a_data = 32'h1111_1111;
      p_v = 1; p_addr = 5'd2; p_data = 32'h2222_2222;
      decide();
      check("cont_alu", alu_wb_ready, (k % 2) == 0);
      check("cont_mem", mem_wb_ready, (k % 2) == 1);
      advance();
    end
    for (int i = 3; i < 32; i++) check("sweep_zero", rf_mem[i], 0);
    decide(); advance();   // remaining ALU request drains

    // Single ALU write, visible in the register file two cycles later.
    a_v = 1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    decide();
    check("alu5_ready", alu_wb_ready, 1);
    advance();
    check("alu5_we", rf_write_enable, 1);
    check("alu5_addr", rf_write_addr, 5);
    decide(); advance();
    check("x5_value", rf_mem[5], 32'hDEAD_BEEF);

    // Load write to x0: accepted, not written.
    p_v = 1; p_addr = 5'd0; p_data = 32'h0000_1234;
    decide();
    check("x0_ready", mem_wb_ready, 1);
    advance();
    check("x0_we", rf_write_enable, 0);
    decide(); advance();
    check("x0_value", rf_mem[0], 0);

    // Random traffic, requests held until the model accepts them.
    for (int n = 0; n < 400; n++) begin
      if (!a_v && ($urandom % 3 != 0)) begin
        a_v = 1; a_addr = 5'($urandom % 32); a_data = $urandom;
      end
      if (!p_v && ($urandom % 3 != 0)) begin
        p_v = 1; p_addr = 5'($urandom % 32); p_data = $urandom;
      end
      decide(); advance();
    end
    for (int n = 0; n < 4; n++) begin
      decide(); advance();
    end
    for (int i = 0; i < 32; i++) check("rf_contents", rf_mem[i], ref_rf[i]);

    // Reset while the sweep is at x10; sweep restarts from x1.
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    decide();
    for (int i = 1; i <= 10; i++) begin
      advance();
      if (i < 10) decide();
    end
    check("mid_addr", rf_write_addr, 10);
    reset = 1;
    #1;
    check("mid_rst_we", rf_write_enable, 0);
    check("mid_rst_addr", rf_write_addr, 0);
    check("mid_rst_data", rf_write_data, 0);
    check("mid_rst_init", init_done, 0);
    @(posedge clk); #1;
    check("mid_rst_hold_we", rf_write_enable, 0);
    reset = 0;
    model_reset();
    decide();
    for (int i = 1; i <= 31; i++) begin
      advance();
      decide();
    end
    advance();
    for (int i = 1; i < 32; i++) check("resweep_zero", rf_mem[i], 0);

    // Instance without the sweep: ready immediately after reset.
    rst0 = 0;
    check("nc_init", init_done0, 1);
    alu_wb_valid = 1; alu_wb_addr = 5'd7; alu_wb_data = 32'hCAFE_F00D;
    mem_wb_valid = 0;
    #1;
    check("nc_alu_ready", alu_ready0, 1);
    check("nc_mem_ready", mem_ready0, 0);
    @(posedge clk); #1;
    alu_wb_valid = 0;
    check("nc_we", rf_we0, 1);
    check("nc_addr", rf_addr0, 7);
    check("nc_data", rf_data0, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
